// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the dual-pattern serial sequence detector.
// Holds the legacy 3-bit pattern values and the fill-counter width rule.
package seq_det_pkg;

    localparam logic [2:0] PAT_101 = 3'b101;
    localparam logic [2:0] PAT_110 = 3'b110;

    // Fill must be able to represent 0..pat_w inclusive.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with a synchronous clear that overrides increment.
// Used once per pattern to tally match pulses.
module seq_det_sat_cnt
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_det_dual_moore.sv
// Moore-style detector for two PAT_W-bit patterns on a qualified serial stream,
// with runtime overlap selection, registered match pulses and saturating counters.
module seq_det_dual_moore
    import seq_det_pkg::*;
#(
    parameter int               PAT_W = 3,
    parameter logic [PAT_W-1:0] PAT_A = PAT_101,
    parameter logic [PAT_W-1:0] PAT_B = PAT_110,
    parameter int               CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic             in,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             match_a,
    output logic             match_b,
    output logic             out,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    localparam int               FILL_W    = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist;
    logic [PAT_W-1:0]  hist_next;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_next;
    logic              hit_a;
    logic              hit_b;
    logic              inc_a;
    logic              inc_b;

    always_comb begin
        hist_next = {hist[PAT_W-2:0], in};
        fill_next = (fill == FILL_FULL) ? fill : fill + 1'b1;
        hit_a     = (fill_next == FILL_FULL) && (hist_next == PAT_A);
        hit_b     = (fill_next == FILL_FULL) && (hist_next == PAT_B);
        inc_a     = in_valid && hit_a;
        inc_b     = in_valid && hit_b;
    end

    // A non-overlapping hit restarts the shared fill count; hist keeps the new
    // bits but they can only match again after PAT_W fresh bits refill it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist    <= '0;
            fill    <= '0;
            match_a <= 1'b0;
            match_b <= 1'b0;
        end else if (in_valid) begin
            hist    <= hist_next;
            fill    <= (!overlap && (hit_a || hit_b)) ? '0 : fill_next;
            match_a <= hit_a;
            match_b <= hit_b;
        end else begin
            match_a <= 1'b0;
            match_b <= 1'b0;
        end
    end

    assign out = match_a | match_b;

    seq_det_sat_cnt #(.CNT_W(CNT_W)) u_cnt_a (
        .clk  (clk),
        .rstn (rstn),
        .inc  (inc_a),
        .clr  (clr_cnt),
        .cnt  (cnt_a)
    );

    seq_det_sat_cnt #(.CNT_W(CNT_W)) u_cnt_b (
        .clk  (clk),
        .rstn (rstn),
        .inc  (inc_b),
        .clr  (clr_cnt),
        .cnt  (cnt_b)
    );

endmodule
